// File: rtl/vga_pkg.sv
// Shared 640x480@60 Hz raster timing constants for the VGA timing generator,
// graphics generator and game logic.
package vga_pkg;

    localparam int unsigned CNT_W    = 12;
    localparam int unsigned CLK_DIV  = 4;
    localparam logic        SYNC_POL = 1'b0;

    localparam int unsigned H_SYNC = 96;
    localparam int unsigned H_BP   = 48;
    localparam int unsigned H_ACT  = 640;
    localparam int unsigned H_FP   = 16;
    localparam int unsigned V_SYNC = 2;
    localparam int unsigned V_BP   = 33;
    localparam int unsigned V_ACT  = 480;
    localparam int unsigned V_FP   = 10;

    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;

    // Counter origin is the start of sync, so active video follows sync + back porch.
    localparam int unsigned H_ACT_START   = H_SYNC + H_BP;
    localparam int unsigned H_ACT_END     = H_ACT_START + H_ACT - 1;
    localparam int unsigned V_ACT_START   = V_SYNC + V_BP;
    localparam int unsigned V_ACT_END     = V_ACT_START + V_ACT - 1;
    localparam int unsigned V_BLANK_START = V_ACT_START + V_ACT;

endpackage

// File: rtl/vga_timing_gen_pixel_tick_gen.sv
// Divides the system clock by CLK_DIV; pix_tick is high in the cycle where
// the divider sits at its terminal count.
module pixel_tick_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_tick
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nx;
    logic             pix_tick_nx;

    always_comb begin
        div_nx      = (div == DIV_LAST) ? '0 : div + DIV_W'(1);
        pix_tick_nx = (div_nx == DIV_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div      <= '0;
            pix_tick <= 1'b0;
        end else begin
            div      <= div_nx;
            pix_tick <= pix_tick_nx;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters plus sync, display enable and
// per-frame strobes, all registered from the next-state counter values.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = vga_pkg::CLK_DIV,
    parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
    parameter int unsigned H_BP     = vga_pkg::H_BP,
    parameter int unsigned H_ACT    = vga_pkg::H_ACT,
    parameter int unsigned H_FP     = vga_pkg::H_FP,
    parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
    parameter int unsigned V_BP     = vga_pkg::V_BP,
    parameter int unsigned V_ACT    = vga_pkg::V_ACT,
    parameter int unsigned V_FP     = vga_pkg::V_FP,
    parameter logic        SYNC_POL = vga_pkg::SYNC_POL
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             hsync,
    output logic             vsync,
    output logic             flag,
    output logic             pix_tick,
    output logic             frame_tick,
    output logic             vblank_tick
);

    localparam int unsigned H_LAST   = H_SYNC + H_BP + H_ACT + H_FP - 1;
    localparam int unsigned V_LAST   = V_SYNC + V_BP + V_ACT + V_FP - 1;
    localparam int unsigned HA_FIRST = H_SYNC + H_BP;
    localparam int unsigned HA_LAST  = HA_FIRST + H_ACT - 1;
    localparam int unsigned VA_FIRST = V_SYNC + V_BP;
    localparam int unsigned VA_LAST  = VA_FIRST + V_ACT - 1;
    localparam int unsigned VB_FIRST = VA_FIRST + V_ACT;

    logic [CNT_W-1:0] h_nx;
    logic [CNT_W-1:0] v_nx;
    logic             hsync_nx;
    logic             vsync_nx;
    logic             flag_nx;
    logic             frame_nx;
    logic             vblank_nx;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .pix_tick (pix_tick)
    );

    // Counters advance at the end of each pix_tick cycle; status decoded from next state.
    always_comb begin
        h_nx = h_cnt;
        v_nx = v_cnt;
        if (pix_tick) begin
            if (h_cnt == CNT_W'(H_LAST)) begin
                h_nx = '0;
                v_nx = (v_cnt == CNT_W'(V_LAST)) ? '0 : v_cnt + CNT_W'(1);
            end else begin
                h_nx = h_cnt + CNT_W'(1);
            end
        end
        hsync_nx  = (h_nx < CNT_W'(H_SYNC)) ? SYNC_POL : ~SYNC_POL;
        vsync_nx  = (v_nx < CNT_W'(V_SYNC)) ? SYNC_POL : ~SYNC_POL;
        flag_nx   = (h_nx >= CNT_W'(HA_FIRST)) && (h_nx <= CNT_W'(HA_LAST)) &&
                    (v_nx >= CNT_W'(VA_FIRST)) && (v_nx <= CNT_W'(VA_LAST));
        frame_nx  = pix_tick && (h_nx == '0) && (v_nx == '0);
        vblank_nx = pix_tick && (h_nx == '0) && (v_nx == CNT_W'(VB_FIRST));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            hsync       <= SYNC_POL;
            vsync       <= SYNC_POL;
            flag        <= 1'b0;
            frame_tick  <= 1'b0;
            vblank_tick <= 1'b0;
        end else begin
            h_cnt       <= h_nx;
            v_cnt       <= v_nx;
            hsync       <= hsync_nx;
            vsync       <= vsync_nx;
            flag        <= flag_nx;
            frame_tick  <= frame_nx;
            vblank_tick <= vblank_nx;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance and a shrunken-raster instance
// compared every cycle against an arithmetic raster model, with random async resets.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [11:0] h;
        logic [11:0] v;
        logic        hs;
        logic        vs;
        logic        fl;
        logic        pt;
        logic        ft;
        logic        vt;
    } vga_obs_t;

    // Shrunken raster: minimum divider, inverted sync polarity, 17x10 pixel frame.
    localparam int S_DIV = 2;
    localparam int S_HS = 4, S_HBP = 3, S_HACT = 8, S_HFP = 2;
    localparam int S_VS = 2, S_VBP = 2, S_VACT = 4, S_VFP = 2;
    localparam logic S_POL = 1'b1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic mon_en = 1'b0;
    int   n_edges;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [11:0] a_h, a_v, b_h, b_v;
    logic a_hs, a_vs, a_fl, a_pt, a_ft, a_vt;
    logic b_hs, b_vs, b_fl, b_pt, b_ft, b_vt;

    always #5 clk = ~clk;

    vga_timing_gen u_std (
        .clk         (clk),
        .rst_n       (rst_n),
        .h_cnt       (a_h),
        .v_cnt       (a_v),
        .hsync       (a_hs),
        .vsync       (a_vs),
        .flag        (a_fl),
        .pix_tick    (a_pt),
        .frame_tick  (a_ft),
        .vblank_tick (a_vt)
    );

    vga_timing_gen #(
        .CLK_DIV (S_DIV), .H_SYNC (S_HS), .H_BP (S_HBP), .H_ACT (S_HACT), .H_FP (S_HFP),
        .V_SYNC (S_VS), .V_BP (S_VBP), .V_ACT (S_VACT), .V_FP (S_VFP), .SYNC_POL (S_POL)
    ) u_small (
        .clk         (clk),
        .rst_n       (rst_n),
        .h_cnt       (b_h),
        .v_cnt       (b_v),
        .hsync       (b_hs),
        .vsync       (b_vs),
        .flag        (b_fl),
        .pix_tick    (b_pt),
        .frame_tick  (b_ft),
        .vblank_tick (b_vt)
    );

    // Clock edges seen since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n_edges <= 0;
        else        n_edges <= n_edges + 1;
    end

    // Raster position after n edges: one pixel per cdiv edges, wrapping per frame.
    function automatic vga_obs_t model(input int n, input int cdiv,
                                       input int hsw, input int hbp, input int hact, input int hfp,
                                       input int vsw, input int vbp, input int vact, input int vfp,
                                       input logic pol);
        vga_obs_t e;
        int ht, vt, p, ph, pos, h, v;
        ht  = hsw + hbp + hact + hfp;
        vt  = vsw + vbp + vact + vfp;
        p   = n / cdiv;
        ph  = n % cdiv;
        pos = p % (ht * vt);
        h   = pos % ht;
        v   = pos / ht;
        e.h  = 12'(h);
        e.v  = 12'(v);
        e.hs = (h < hsw) ? pol : ~pol;
        e.vs = (v < vsw) ? pol : ~pol;
        e.fl = (h >= hsw + hbp) && (h < hsw + hbp + hact) &&
               (v >= vsw + vbp) && (v < vsw + vbp + vact);
        e.pt = (ph == cdiv - 1);
        e.ft = (p > 0) && (pos == 0) && (ph == 0);
        e.vt = (pos == (vsw + vbp + vact) * ht) && (ph == 0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d (edge %0d, t=%0t)", tag, obs, exp, n_edges, $time);
        end
    endtask

    task automatic chk_vec(input string who, input vga_obs_t o, input vga_obs_t e);
        chk({who, ".h_cnt"},       32'(o.h),  32'(e.h));
        chk({who, ".v_cnt"},       32'(o.v),  32'(e.v));
        chk({who, ".hsync"},       32'(o.hs), 32'(e.hs));
        chk({who, ".vsync"},       32'(o.vs), 32'(e.vs));
        chk({who, ".flag"},        32'(o.fl), 32'(e.fl));
        chk({who, ".pix_tick"},    32'(o.pt), 32'(e.pt));
        chk({who, ".frame_tick"},  32'(o.ft), 32'(e.ft));
        chk({who, ".vblank_tick"}, 32'(o.vt), 32'(e.vt));
    endtask

    task automatic check_both(input string phase);
        vga_obs_t oa, ob;
        oa = '{h: a_h, v: a_v, hs: a_hs, vs: a_vs, fl: a_fl, pt: a_pt, ft: a_ft, vt: a_vt};
        ob = '{h: b_h, v: b_v, hs: b_hs, vs: b_vs, fl: b_fl, pt: b_pt, ft: b_ft, vt: b_vt};
        chk_vec({phase, ":std"}, oa,
                model(n_edges, vga_pkg::CLK_DIV, vga_pkg::H_SYNC, vga_pkg::H_BP, vga_pkg::H_ACT,
                      vga_pkg::H_FP, vga_pkg::V_SYNC, vga_pkg::V_BP, vga_pkg::V_ACT,
                      vga_pkg::V_FP, vga_pkg::SYNC_POL));
        chk_vec({phase, ":small"}, ob,
                model(n_edges, S_DIV, S_HS, S_HBP, S_HACT, S_HFP, S_VS, S_VBP, S_VACT, S_VFP, S_POL));
    endtask

    always @(negedge clk) begin
        if (mon_en) check_both("run");
    end

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (20000) @(posedge clk);

        // Random mid-frame asynchronous resets, checked before the next clock edge.
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(9000, 2000)) @(posedge clk);
            #($urandom_range(3, 1));
            rst_n = 1'b0;
            #1 check_both("async");
            repeat ($urandom_range(5, 2)) @(negedge clk);
            #1 rst_n = 1'b1;
        end

        repeat (4000) @(posedge clk);
        @(negedge clk);
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
